// File: rtl/timer_pkg.sv
// timer_pkg: shared defaults, mode encodings and width helpers for the timer event controller
package timer_pkg;
  localparam int N_CH_DEF = 4;
  localparam int MISS_W_DEF = 4;
  localparam logic MODE_STICKY = 1'b0;
  localparam logic MODE_PULSE = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction
  function automatic int idWidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/timer_event_channel.sv
// timer_event_channel: one channel's edge detect, event flag and saturating miss counter
// Ports: iClk/iReset (async, active-high), iComparisonTrue compare-match level,
//   iEnable event enable, iModePulse 0=sticky 1=pulse, iAck clears flag/counter,
//   oFlag registered event flag, oMissCount events lost while the flag was pending.
module timer_event_channel
  import timer_pkg::*;
#(
  parameter int MISS_W = MISS_W_DEF,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iComparisonTrue,
  input  logic              iEnable,
  input  logic              iModePulse,
  input  logic              iAck,
  output logic              oFlag,
  output logic [MISS_W-1:0] oMissCount
);
  logic prev;
  logic ev;
  assign ev = iEnable & (EDGE_DETECT ? (iComparisonTrue & ~prev) : iComparisonTrue);
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      prev <= 1'b0;
      oFlag <= 1'b0;
      oMissCount <= '0;
    end else begin
      prev <= iComparisonTrue;
      if (iModePulse == MODE_PULSE) begin
        oFlag <= ev;
        if (iAck) oMissCount <= '0;
      end else if (ev & oFlag & ~iAck) begin
        oMissCount <= (&oMissCount) ? oMissCount : oMissCount + 1'b1;
      end else if (iAck) begin
        // a fresh event in the ack cycle keeps the flag raised
        oFlag <= ev;
        oMissCount <= '0;
      end else if (ev) begin
        oFlag <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/timer_event_ctrl.sv
// timer_event_ctrl: multi-channel compare-match event capture with prioritised interrupt
// Ports: iClk/iReset (async, active-high), per-channel iComparisonTrue/iEnable/iModePulse/iAck,
//   oFlag per-channel flags, oIrq any enabled flag, oIrqId lowest enabled flagged channel,
//   oMissCount channel i at [i*MISS_W +: MISS_W].
module timer_event_ctrl
  import timer_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int MISS_W = MISS_W_DEF,
  parameter bit EDGE_DETECT = 1'b1,
  localparam int ID_W = idWidth(N_CH)
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic [N_CH-1:0]          iComparisonTrue,
  input  logic [N_CH-1:0]          iEnable,
  input  logic [N_CH-1:0]          iModePulse,
  input  logic [N_CH-1:0]          iAck,
  output logic [N_CH-1:0]          oFlag,
  output logic                     oIrq,
  output logic [ID_W-1:0]          oIrqId,
  output logic [N_CH*MISS_W-1:0]   oMissCount
);
  logic [N_CH-1:0] masked;
  for (genvar g = 0; g < N_CH; g++) begin : gCh
    timer_event_channel #(.MISS_W(MISS_W), .EDGE_DETECT(EDGE_DETECT)) uCh (
      .iClk           (iClk),
      .iReset         (iReset),
      .iComparisonTrue(iComparisonTrue[g]),
      .iEnable        (iEnable[g]),
      .iModePulse     (iModePulse[g]),
      .iAck           (iAck[g]),
      .oFlag          (oFlag[g]),
      .oMissCount     (oMissCount[g*MISS_W +: MISS_W])
    );
  end
  assign masked = oFlag & iEnable;
  assign oIrq = |masked;
  // scan high to low so the lowest set index is written last
  always_comb begin
    oIrqId = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (masked[i]) oIrqId = ID_W'(i);
  end
endmodule

// File: tb/tb_timer_event_ctrl.sv
// tb_timer_event_ctrl: directed bench comparing an edge-detect and a level DUT against a behavioural model
module tb_timer_event_ctrl;
  logic iClk = 1'b0;
  logic iReset = 1'b1;
  logic [3:0] cmp = '0, en = 4'hF, mp = '0, ack = '0;
  logic [3:0] flagE, flagL;
  logic irqE, irqL;
  logic [1:0] idE, idL;
  logic [15:0] missE, missL;
  int tests = 0, fails = 0;

  always #5 iClk = ~iClk;

  timer_event_ctrl #(.N_CH(4), .MISS_W(4), .EDGE_DETECT(1'b1)) dutE (
    .iClk(iClk), .iReset(iReset), .iComparisonTrue(cmp), .iEnable(en), .iModePulse(mp),
    .iAck(ack), .oFlag(flagE), .oIrq(irqE), .oIrqId(idE), .oMissCount(missE));
  timer_event_ctrl #(.N_CH(4), .MISS_W(4), .EDGE_DETECT(1'b0)) dutL (
    .iClk(iClk), .iReset(iReset), .iComparisonTrue(cmp), .iEnable(en), .iModePulse(mp),
    .iAck(ack), .oFlag(flagL), .oIrq(irqL), .oIrqId(idL), .oMissCount(missL));

  // model state: index 0 = edge-detect DUT, 1 = level DUT
  bit mFlag[2][4];
  bit mPrev[2][4];
  int mMiss[2][4];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        bit ev;
        ev = en[i] && cmp[i] && (d == 1 || !mPrev[d][i]);
        if (mp[i]) begin
          mFlag[d][i] = ev;
          if (ack[i]) mMiss[d][i] = 0;
        end else if (ev && mFlag[d][i] && !ack[i]) mMiss[d][i] = (mMiss[d][i] < 15) ? mMiss[d][i] + 1 : 15;
        else if (ev && ack[i]) begin
          mFlag[d][i] = 1;
          mMiss[d][i] = 0;
        end else if (ack[i]) begin
          mFlag[d][i] = 0;
          mMiss[d][i] = 0;
        end else if (ev) mFlag[d][i] = 1;
        mPrev[d][i] = cmp[i];
      end
  endtask

  task automatic modelCheck(input int d, input logic [3:0] f, input logic irq, input logic [1:0] id,
                            input logic [15:0] miss);
    int expFlag, expIrq, expId;
    expFlag = 0;
    expIrq = 0;
    expId = -1;
    for (int i = 0; i < 4; i++) begin
      expFlag += int'(mFlag[d][i]) << i;
      if (mFlag[d][i] && en[i]) begin
        expIrq = 1;
        if (expId < 0) expId = i;
      end
    end
    if (expId < 0) expId = 0;
    chk(d ? "cmp_flag_L" : "cmp_flag_E", int'(f), expFlag);
    chk(d ? "cmp_irq_L" : "cmp_irq_E", int'(irq), expIrq);
    chk(d ? "cmp_id_L" : "cmp_id_E", int'(id), expId);
    for (int i = 0; i < 4; i++) chk(d ? "cmp_miss_L" : "cmp_miss_E", int'(miss[i*4 +: 4]), mMiss[d][i]);
  endtask

  always @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) begin
          mFlag[d][i] = 0;
          mPrev[d][i] = 0;
          mMiss[d][i] = 0;
        end
    end else begin
      modelStep();
      #2;
      modelCheck(0, flagE, irqE, idE, missE);
      modelCheck(1, flagL, irqL, idL, missL);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic clearAll();
    cmp = '0;
    ack = 4'hF;
    cyc(1);
    ack = '0;
  endtask

  initial begin
    cyc(2);
    iReset = 1'b0;
    cyc(1);
    chk("reset_flag", int'(flagE), 0);
    chk("reset_irq", int'(irqE), 0);
    chk("reset_miss", int'(missE), 0);
    // sticky capture and ack on channel 2
    cmp = 4'b0100;
    cyc(1);
    cmp = '0;
    chk("sticky_flag", int'(flagE), 4);
    chk("sticky_irq", int'(irqE), 1);
    chk("sticky_id", int'(idE), 2);
    cyc(10);
    chk("sticky_hold", int'(flagE), 4);
    ack = 4'b0100;
    cyc(1);
    ack = '0;
    chk("ack_flag", int'(flagE), 0);
    chk("ack_irq", int'(irqE), 0);
    // 21 rising edges on channel 1: one capture plus 20 misses
    for (int k = 0; k < 21; k++) begin
      cmp[1] = 1'b1;
      cyc(1);
      cmp[1] = 1'b0;
      cyc(1);
    end
    chk("miss_sat_E", int'(missE[7:4]), 15);
    chk("miss_sat_L", int'(missL[7:4]), 15);
    cmp[1] = 1'b1;
    ack[1] = 1'b1;
    cyc(1);
    cmp = '0;
    ack = '0;
    chk("ack_ev_flag", int'(flagE[1]), 1);
    chk("ack_ev_miss", int'(missE[7:4]), 0);
    clearAll();
    // priority and masking
    cmp = 4'b1010;
    cyc(1);
    cmp = '0;
    chk("prio_id", int'(idE), 1);
    en = 4'b1101;
    #1;
    chk("mask_id", int'(idE), 3);
    chk("mask_irq", int'(irqE), 1);
    chk("mask_flag1", int'(flagE[1]), 1);
    ack = 4'b1000;
    cyc(1);
    ack = '0;
    chk("mask_ack_irq", int'(irqE), 0);
    en = 4'hF;
    clearAll();
    // pulse mode on channel 0
    mp = 4'b0001;
    cmp[0] = 1'b1;
    cyc(1);
    cmp[0] = 1'b0;
    chk("pulse_hi", int'(flagE[0]), 1);
    cyc(1);
    chk("pulse_lo", int'(flagE[0]), 0);
    cmp[0] = 1'b1;
    ack[0] = 1'b1;
    cyc(1);
    cmp[0] = 1'b0;
    ack[0] = 1'b0;
    chk("pulse_ack_flag", int'(flagE[0]), 1);
    chk("pulse_miss", int'(missE[3:0]), 0);
    mp = '0;
    clearAll();
    // level vs edge: 5 high cycles in sticky mode
    cmp[0] = 1'b1;
    cyc(5);
    cmp[0] = 1'b0;
    chk("level_miss", int'(missL[3:0]), 4);
    chk("edge_miss", int'(missE[3:0]), 0);
    // asynchronous reset mid-cycle with a flag pending
    #1;
    iReset = 1'b1;
    #1;
    chk("areset_flag", int'(flagE | flagL), 0);
    chk("areset_irq", int'(irqE | irqL), 0);
    chk("areset_id", int'(idE | idL), 0);
    chk("areset_miss", int'(missE | missL), 0);
    // level held through reset counts as an edge on the first clock
    cmp = 4'b1000;
    cyc(2);
    iReset = 1'b0;
    cyc(1);
    chk("post_reset_flag", int'(flagE), 8);
    chk("post_reset_id", int'(idE), 3);
    cmp = '0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
